mod_arbiter: RTL and testbench

MOD_ARBITER -- requirements
Module: mod_arbiter

---
 rtl/mod_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mod_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_arbiter.sv
// ---------------------------------------------------------------------------
// mod_arbiter
//
// Shares one pipelined 64/16 remainder divider between NUM_REQ requesters.
// A round-robin arbiter accepts at most one request per cycle and issues it
// to the divider one cycle later. A tag pipeline of LATENCY+1 stages follows
// each accepted request so the remainder can be routed back to its owner.
// A zero divisor is never sent to the divider; it travels down the tag
// pipeline flagged as an error and comes back with RSP_ERR set.
//
// Ports
//   CLK           sole clock, all logic on the rising edge
//   RST_N         synchronous active-low reset
//   REQ_VALID     per-requester request valid            [NUM_REQ]
//   REQ_DIVIDEND  per-requester dividend, 64 bits each   [NUM_REQ*64]
//   REQ_DIVISOR   per-requester divisor, 16 bits each    [NUM_REQ*16]
//   REQ_READY     combinational one-hot grant            [NUM_REQ]
//   DIV_DIVIDEND  registered dividend to the divider
//   DIV_DIVISOR   registered divisor to the divider
//   DIV_VALID     registered issue strobe to the divider
//   DIV_REM       remainder returned by the divider
//   DIV_REM_VALID divider output valid
//   RSP_VALID     one-cycle response strobe per requester [NUM_REQ]
//   RSP_REM       shared response remainder
//   RSP_ERR       response carries a zero-divisor error
//   PIPE_ERR      sticky: divider failed to return an expected result
// ---------------------------------------------------------------------------
module mod_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 67
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NUM_REQ-1:0]    REQ_VALID,
  input  logic [NUM_REQ*64-1:0] REQ_DIVIDEND,
  input  logic [NUM_REQ*16-1:0] REQ_DIVISOR,
  output logic [NUM_REQ-1:0]    REQ_READY,
  output logic [63:0]           DIV_DIVIDEND,
  output logic [15:0]           DIV_DIVISOR,
  output logic                  DIV_VALID,
  input  logic [15:0]           DIV_REM,
  input  logic                  DIV_REM_VALID,
  output logic [NUM_REQ-1:0]    RSP_VALID,
  output logic [15:0]           RSP_REM,
  output logic                  RSP_ERR,
  output logic                  PIPE_ERR
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [IW-1:0]      ptr;
  logic [NUM_REQ-1:0] outstanding;
  logic [NUM_REQ-1:0] eligible;
  logic               found;
  logic [IW-1:0]      grantIdx;
  logic [IW:0]        cand;
  logic [63:0]        selDividend;
  logic [15:0]        selDivisor;
  logic               selZero;

  logic [LATENCY:0]   tagValid;
  logic [LATENCY:0]   tagErr;
  logic [IW-1:0]      tagIdx [LATENCY+1];

  logic               expValid;
  logic               expErr;
  logic [NUM_REQ-1:0] expOneHot;

  // A requester may compete only when it is asking, has nothing in flight,
  // and the block is out of reset. Gating with RST_N here keeps REQ_READY
  // low during reset without a separate path.
  assign eligible = REQ_VALID & ~outstanding & {NUM_REQ{RST_N}};

  // Round-robin search: walk PTR, PTR+1, ... with wrap and take the first
  // eligible index. The candidate is one bit wider so the wrap can be done
  // with a compare-and-subtract for any NUM_REQ, not just powers of two.
  always_comb begin
    found    = 1'b0;
    grantIdx = '0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) begin
        cand = cand - (IW+1)'(NUM_REQ);
      end
      if (!found && eligible[cand[IW-1:0]]) begin
        found    = 1'b1;
        grantIdx = cand[IW-1:0];
      end
    end
  end

  assign REQ_READY   = found ? (ONE_HOT0 << grantIdx) : '0;
  assign selDividend = REQ_DIVIDEND[64*int'(grantIdx) +: 64];
  assign selDivisor  = REQ_DIVISOR[16*int'(grantIdx) +: 16];
  assign selZero     = (selDivisor == 16'd0);

  // Pointer moves past the winner only on an accept; idle cycles leave it.
  // Outstanding bits are set on accept and dropped after the response cycle,
  // so the requester becomes eligible again the cycle after RSP_VALID.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ptr         <= '0;
      outstanding <= '0;
    end else begin
      if (found) begin
        if (grantIdx == IW'(NUM_REQ-1)) begin
          ptr <= '0;
        end else begin
          ptr <= grantIdx + 1'b1;
        end
      end
      outstanding <= (outstanding & ~RSP_VALID) | REQ_READY;
    end
  end

  // Divider issue stage. Operands are only reloaded on a real issue, so the
  // divider inputs hold steady on idle cycles and on zero-divisor accepts.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      DIV_VALID    <= 1'b0;
      DIV_DIVIDEND <= '0;
      DIV_DIVISOR  <= '0;
    end else begin
      DIV_VALID <= found && !selZero;
      if (found && !selZero) begin
        DIV_DIVIDEND <= selDividend;
        DIV_DIVISOR  <= selDivisor;
      end
    end
  end

  // Tag pipeline valid/error bits. Stage 0 is loaded in the cycle the issue
  // appears on the divider, so the last stage lines up with the divider
  // output LATENCY cycles later.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      tagValid <= '0;
      tagErr   <= '0;
    end else begin
      tagValid <= {tagValid[LATENCY-1:0], found};
      tagErr   <= {tagErr[LATENCY-1:0], found && selZero};
    end
  end

  // Requester indices ride alongside the valid bits; they are meaningless
  // while the matching valid bit is low, so they need no reset.
  always_ff @(posedge CLK) begin
    tagIdx[0] <= grantIdx;
    for (int s = LATENCY; s > 0; s--) begin
      tagIdx[s] <= tagIdx[s-1];
    end
  end

  assign expValid  = tagValid[LATENCY];
  assign expErr    = tagErr[LATENCY];
  assign expOneHot = ONE_HOT0 << tagIdx[LATENCY];

  // Response stage. A divider result is only taken when a non-error tag is
  // expiring; stray DIV_REM_VALID pulses are ignored. A missing result still
  // produces the response (with a zero remainder) and latches PIPE_ERR.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      RSP_VALID <= '0;
      RSP_REM   <= '0;
      RSP_ERR   <= 1'b0;
      PIPE_ERR  <= 1'b0;
    end else begin
      RSP_VALID <= expValid ? expOneHot : '0;
      RSP_ERR   <= expValid && expErr;
      RSP_REM   <= (expValid && !expErr && DIV_REM_VALID) ? DIV_REM : '0;
      if (expValid && !expErr && !DIV_REM_VALID) begin
        PIPE_ERR <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mod_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mod_arbiter
//
// Self-checking bench for mod_arbiter. A behavioural divider answers issues
// after LATENCY cycles (optionally dropping one). A reference model tracks,
// per cycle, which requester should be granted and what response each
// accept should produce LATENCY+2 cycles later, and every cycle the DUT
// outputs are compared against it.
// ---------------------------------------------------------------------------
module tb_mod_arbiter;

  localparam int NREQ    = 4;
  localparam int LAT     = 67;
  localparam int RSP_OFS = LAT + 2;
  localparam int MAXCYC  = 4000;

  logic                CLK;
  logic                RST_N;
  logic [NREQ-1:0]     REQ_VALID;
  logic [NREQ*64-1:0]  REQ_DIVIDEND;
  logic [NREQ*16-1:0]  REQ_DIVISOR;
  logic [NREQ-1:0]     REQ_READY;
  logic [63:0]         DIV_DIVIDEND;
  logic [15:0]         DIV_DIVISOR;
  logic                DIV_VALID;
  logic [15:0]         DIV_REM;
  logic                DIV_REM_VALID;
  logic [NREQ-1:0]     RSP_VALID;
  logic [15:0]         RSP_REM;
  logic                RSP_ERR;
  logic                PIPE_ERR;

  mod_arbiter #(.NUM_REQ(NREQ), .LATENCY(LAT)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .REQ_VALID(REQ_VALID),
    .REQ_DIVIDEND(REQ_DIVIDEND),
    .REQ_DIVISOR(REQ_DIVISOR),
    .REQ_READY(REQ_READY),
    .DIV_DIVIDEND(DIV_DIVIDEND),
    .DIV_DIVISOR(DIV_DIVISOR),
    .DIV_VALID(DIV_VALID),
    .DIV_REM(DIV_REM),
    .DIV_REM_VALID(DIV_REM_VALID),
    .RSP_VALID(RSP_VALID),
    .RSP_REM(RSP_REM),
    .RSP_ERR(RSP_ERR),
    .PIPE_ERR(PIPE_ERR)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state
  int              mPtr;
  int              busyUntil [NREQ];
  logic [NREQ-1:0] expRspValid [MAXCYC];
  logic [15:0]     expRspRem   [MAXCYC];
  logic            expRspErr   [MAXCYC];
  logic            expDivValid [MAXCYC];
  logic [63:0]     curDvd, newDvd;
  logic [15:0]     curDvs, newDvs;
  int              newCycle;
  int              pipeSetAt;
  int              pipeClrAt;
  logic            dropReq;
  int              dropCycle;
  logic            spurious;
  logic [63:0]     reqDvd [NREQ];
  logic [15:0]     reqDvs [NREQ];

  // Clock generation and cycle counter
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    forever begin
      @(posedge CLK);
      cyc++;
    end
  end

  // Behavioural divider: every issue seen on DIV_VALID returns its remainder
  // exactly LAT cycles later, unless it was marked for dropping. Outside a
  // result cycle the remainder bus carries junk, and in the random phase an
  // occasional stray valid pulse is injected.
  initial begin
    int          dueQ [$];
    logic [15:0] remQ [$];
    logic        vldQ [$];
    logic [63:0] r;
    DIV_REM       = '0;
    DIV_REM_VALID = 1'b0;
    forever begin
      @(negedge CLK);
      DIV_REM       = 16'($urandom);
      DIV_REM_VALID = 1'b0;
      if (dueQ.size() > 0 && dueQ[0] == cyc) begin
        DIV_REM_VALID = vldQ[0];
        if (vldQ[0]) DIV_REM = remQ[0];
        void'(dueQ.pop_front());
        void'(remQ.pop_front());
        void'(vldQ.pop_front());
      end else if (spurious && $urandom_range(7) == 0) begin
        DIV_REM_VALID = 1'b1;
      end
      if (DIV_VALID === 1'b1) begin
        r = DIV_DIVIDEND % {48'd0, DIV_DIVISOR};
        dueQ.push_back(cyc + LAT);
        remQ.push_back(r[15:0]);
        vldQ.push_back(cyc != dropCycle);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic expPipe(input int x);
    return (pipeSetAt >= 0) && (x >= pipeSetAt) &&
           !((pipeClrAt > pipeSetAt) && (x >= pipeClrAt));
  endfunction

  // Round-robin rule: first requester that is asking and idle, searching
  // from the pointer with wrap.
  function automatic int modelGrant(input logic rstN, input logic [NREQ-1:0] valid, input int x);
    if (!rstN) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (mPtr + k) % NREQ;
      if (valid[i] && x > busyUntil[i]) return i;
    end
    return -1;
  endfunction

  task automatic modelAccept(input int x, input int i);
    logic [63:0] r;
    int          t;
    t = x + RSP_OFS;
    mPtr         = (i + 1) % NREQ;
    busyUntil[i] = t;
    expRspValid[t] = '0;
    expRspValid[t][i] = 1'b1;
    if (reqDvs[i] == 16'd0) begin
      expRspErr[t] = 1'b1;
      expRspRem[t] = '0;
    end else begin
      expRspErr[t]    = 1'b0;
      expDivValid[x+1] = 1'b1;
      newDvd   = reqDvd[i];
      newDvs   = reqDvs[i];
      newCycle = x + 1;
      if (dropReq) begin
        dropReq      = 1'b0;
        dropCycle    = x + 1;
        expRspRem[t] = '0;
        if (pipeSetAt < 0 || pipeSetAt < pipeClrAt) pipeSetAt = t;
      end else begin
        r = reqDvd[i] % {48'd0, reqDvs[i]};
        expRspRem[t] = r[15:0];
      end
    end
  endtask

  // Reset sampled at the end of cycle r: everything scheduled after r is
  // discarded and the block restarts clean from r+1.
  task automatic modelReset(input int r);
    mPtr = 0;
    for (int i = 0; i < NREQ; i++) busyUntil[i] = r;
    for (int c = r + 1; c < MAXCYC && c <= r + RSP_OFS + 2; c++) begin
      expRspValid[c] = '0;
      expRspRem[c]   = '0;
      expRspErr[c]   = 1'b0;
      expDivValid[c] = 1'b0;
    end
    newDvd   = '0;
    newDvs   = '0;
    newCycle = r + 1;
    if (pipeSetAt > r) pipeSetAt = -1;
    pipeClrAt = r + 1;
  endtask

  task automatic checkOutput(input logic [NREQ-1:0] expReady);
    int x;
    x = cyc;
    if (x >= newCycle) begin
      curDvd = newDvd;
      curDvs = newDvs;
    end
    chk("REQ_READY",    64'(REQ_READY),    64'(expReady));
    chk("RSP_VALID",    64'(RSP_VALID),    64'(expRspValid[x]));
    chk("RSP_REM",      64'(RSP_REM),      64'(expRspRem[x]));
    chk("RSP_ERR",      64'(RSP_ERR),      64'(expRspErr[x]));
    chk("PIPE_ERR",     64'(PIPE_ERR),     64'(expPipe(x)));
    chk("DIV_VALID",    64'(DIV_VALID),    64'(expDivValid[x]));
    chk("DIV_DIVIDEND", DIV_DIVIDEND,      curDvd);
    chk("DIV_DIVISOR",  64'(DIV_DIVISOR),  64'(curDvs));
  endtask

  // One clock cycle: drive inputs at the falling edge, let the combinational
  // grant settle, compare everything, then advance the reference model.
  task automatic applyStimulus(input logic rstN, input logic [NREQ-1:0] valid);
    int              g;
    int              x;
    logic [NREQ-1:0] expReady;
    @(negedge CLK);
    RST_N     = rstN;
    REQ_VALID = valid;
    for (int i = 0; i < NREQ; i++) begin
      REQ_DIVIDEND[i*64 +: 64] = reqDvd[i];
      REQ_DIVISOR[i*16 +: 16]  = reqDvs[i];
    end
    #1;
    x = cyc;
    if (x >= MAXCYC - RSP_OFS - 3) begin
      $display("[TB] FAIL cycle_budget observed %0d required below %0d", x, MAXCYC - RSP_OFS - 3);
      $fatal(1, "[TB] cycle budget exhausted");
    end
    g = modelGrant(rstN, valid, x);
    expReady = '0;
    if (g >= 0) expReady[g] = 1'b1;
    checkOutput(expReady);
    if (!rstN) modelReset(x);
    else if (g >= 0) modelAccept(x, g);
  endtask

  task automatic hold(input logic [NREQ-1:0] valid, input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, valid);
  endtask

  task automatic setReq(input int i, input logic [63:0] dvd, input logic [15:0] dvs);
    reqDvd[i] = dvd;
    reqDvs[i] = dvs;
  endtask

  initial begin
    RST_N        = 1'b0;
    REQ_VALID    = '0;
    REQ_DIVIDEND = '0;
    REQ_DIVISOR  = '0;
    mPtr      = 0;
    curDvd    = '0; newDvd = '0;
    curDvs    = '0; newDvs = '0;
    newCycle  = 0;
    pipeSetAt = -1;
    pipeClrAt = 0;
    dropReq   = 1'b0;
    dropCycle = -1;
    spurious  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      busyUntil[i] = -1;
      reqDvd[i]    = '0;
      reqDvs[i]    = 16'd1;
    end
    for (int c = 0; c < MAXCYC; c++) begin
      expRspValid[c] = '0;
      expRspRem[c]   = '0;
      expRspErr[c]   = 1'b0;
      expDivValid[c] = 1'b0;
    end
    repeat (2) @(posedge CLK);

    // Reset state, with every requester asking
    $display("[TB] reset state");
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 4'hF);

    // Single request 1000 % 300, kept asking to see the re-grant at T+70
    $display("[TB] single request");
    setReq(0, 64'd1000, 16'd300);
    hold(4'b0001, 71);
    hold(4'b0000, 72);

    // All four asking continuously from reset
    $display("[TB] all requesters from reset");
    applyStimulus(1'b0, 4'h0);
    setReq(1, 64'd123456789, 16'd1000);
    setReq(2, 64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF);
    setReq(3, 64'd65535, 16'd256);
    hold(4'hF, 75);
    hold(4'h0, 75);

    // Zero divisor on requester 2
    $display("[TB] zero divisor");
    setReq(2, 64'd12345, 16'd0);
    hold(4'b0100, 1);
    hold(4'b0000, 72);

    // Divider drops one result; later ones must still be right
    $display("[TB] dropped divider result");
    dropReq = 1'b1;
    setReq(1, 64'd777777, 16'd1234);
    hold(4'b0010, 1);
    setReq(3, 64'd99999, 16'd17);
    hold(4'b1000, 1);
    hold(4'b0000, 72);
    setReq(0, 64'd500, 16'd7);
    hold(4'b0001, 1);
    hold(4'b0000, 72);

    // Reset 30 cycles after an accept discards the request
    $display("[TB] reset mid-flight");
    applyStimulus(1'b0, 4'h0);
    setReq(0, 64'd4242, 16'd100);
    hold(4'b0001, 1);
    hold(4'b0000, 29);
    applyStimulus(1'b0, 4'h0);
    hold(4'b0000, 45);
    setReq(0, 64'd31337, 16'd1000);
    hold(4'b0001, 1);
    hold(4'b0000, 72);

    // Pointer at 2 with requesters 0 and 3 asking
    $display("[TB] round-robin wrap");
    applyStimulus(1'b0, 4'h0);
    setReq(1, 64'd10, 16'd3);
    setReq(0, 64'd200, 16'd9);
    setReq(3, 64'd300, 16'd11);
    hold(4'b0010, 1);
    hold(4'b1001, 2);
    hold(4'b0000, 72);

    // Randomised traffic with stray divider pulses, drops and resets
    $display("[TB] random traffic");
    spurious = 1'b1;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        reqDvd[i] = {$urandom, $urandom};
        reqDvs[i] = ($urandom_range(7) == 0) ? 16'd0 : 16'($urandom);
      end
      if (!dropReq && $urandom_range(49) == 0) dropReq = 1'b1;
      if ($urandom_range(199) == 0) applyStimulus(1'b0, 4'($urandom));
      else applyStimulus(1'b1, 4'($urandom));
    end
    hold(4'b0000, 75);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
